score_digits_ctrl: RTL and testbench

Sequencer that feeds the 16x32 digit-glyph renderer with a multi-digit decimal number. Once per frame it converts a binary score to BCD with a serial double-dabble engine, double-buffers the result so a conversion never tears a visible frame, and maps each VGA pixel to a digit slot. For each pixel it drives the renderer's `digit`, `offsetX`, `offsetY` and `InsideRectangle` inputs, blanking leading zeros. It sits between the game-logic score register and the digit bitmap block.

---
 rtl/score_digits_ctrl_if.sv | 26 ++
 rtl/score_digits_ctrl.sv | 148 ++++++++++++++
 tb/tb_score_digits_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/score_digits_ctrl_if.sv
// Score/pixel bus between the game/VGA side and the digit sequencer.
// The game side drives the score and pixel position; the sequencer returns renderer inputs and status.
interface score_digits_ctrl_if #(
    parameter int VALUE_W = 14
);
    logic               startOfFrame;
    logic [VALUE_W-1:0] value;
    logic [10:0]        pixelX;
    logic [10:0]        pixelY;
    logic               InsideRectangle;
    logic [10:0]        offsetX;
    logic [10:0]        offsetY;
    logic [7:0]         digit;
    logic               busy;
    logic               overflow;

    modport master (
        output startOfFrame, value, pixelX, pixelY,
        input  InsideRectangle, offsetX, offsetY, digit, busy, overflow
    );

    modport slave (
        input  startOfFrame, value, pixelX, pixelY,
        output InsideRectangle, offsetX, offsetY, digit, busy, overflow
    );
endinterface

// File: rtl/score_digits_ctrl.sv
// Per-frame serial binary-to-BCD conversion into a double-buffered display register,
// plus registered pixel-to-digit-slot mapping with leading-zero blanking.
module score_digits_ctrl #(
    parameter int          NUM_DIGITS    = 4,
    parameter int          VALUE_W       = 14,
    parameter int          DIGIT_W       = 16,
    parameter int          DIGIT_H       = 32,
    parameter logic [10:0] TOP_LEFT_X    = 11'd20,
    parameter logic [10:0] TOP_LEFT_Y    = 11'd20,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input logic                clk,
    input logic                resetN,
    score_digits_ctrl_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int LOG2W = $clog2(DIGIT_W);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(NUM_DIGITS) - 1;
    localparam bit              CAN_SAT = MAX_DEC < (64'd1 << VALUE_W);
    localparam logic [VALUE_W-1:0] SAT_VAL = CAN_SAT ? VALUE_W'(MAX_DEC) : '1;

    localparam logic [31:0] X_LO = 32'(TOP_LEFT_X);
    localparam logic [31:0] X_HI = X_LO + 32'(NUM_DIGITS * DIGIT_W);
    localparam logic [31:0] Y_LO = 32'(TOP_LEFT_Y);
    localparam logic [31:0] Y_HI = Y_LO + 32'(DIGIT_H);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t             state, state_n;
    logic [VALUE_W-1:0] shreg, sh_n;
    logic [BCD_W-1:0]   bcd, bcd_n, adj;
    logic [BCD_W-1:0]   disp, disp_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pend_ovf, pend_n;
    logic               ovf_q, ovf_n;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            disp     <= '0;
            cnt      <= '0;
            pend_ovf <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= sh_n;
            bcd      <= bcd_n;
            disp     <= disp_n;
            cnt      <= cnt_n;
            pend_ovf <= pend_n;
            ovf_q    <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = shreg;
        bcd_n   = bcd;
        disp_n  = disp;
        cnt_n   = cnt;
        pend_n  = pend_ovf;
        ovf_n   = ovf_q;
        adj     = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE: begin
                if (bus.startOfFrame) begin
                    state_n = CONVERT;
                    if (CAN_SAT && (64'(bus.value) > MAX_DEC)) begin
                        sh_n   = SAT_VAL;
                        pend_n = 1'b1;
                    end else begin
                        sh_n   = bus.value;
                        pend_n = 1'b0;
                    end
                    cnt_n = CNT_W'(VALUE_W - 1);
                    bcd_n = '0;
                end
            end
            CONVERT: begin
                bcd_n = {adj[BCD_W-2:0], shreg[VALUE_W-1]};
                sh_n  = shreg << 1;
                cnt_n = cnt - 1'b1;
                if (cnt == '0) state_n = COMMIT;
            end
            COMMIT: begin
                disp_n  = bcd;
                ovf_n   = pend_ovf;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf_q;

    logic [31:0] px32, py32;
    logic        in_area, blank, zero_run;
    logic [10:0] dx, dy, slot;
    logic [3:0]  nib;

    always_comb begin
        px32     = {21'b0, bus.pixelX};
        py32     = {21'b0, bus.pixelY};
        in_area  = (px32 >= X_LO) && (px32 < X_HI) && (py32 >= Y_LO) && (py32 < Y_HI);
        dx       = bus.pixelX - TOP_LEFT_X;
        dy       = bus.pixelY - TOP_LEFT_Y;
        slot     = dx >> LOG2W;
        nib      = '0;
        blank    = 1'b0;
        zero_run = 1'b1;
        // Slot 0 is the most significant nibble; zero_run tracks "all zero so far".
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (disp[BCD_W-1-4*i -: 4] == 4'd0);
            if (slot == 11'(i)) begin
                nib   = disp[BCD_W-1-4*i -: 4];
                blank = BLANK_LEADING && (i < NUM_DIGITS - 1) && zero_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || !in_area || blank) begin
            bus.InsideRectangle <= 1'b0;
            bus.offsetX         <= '0;
            bus.offsetY         <= '0;
            bus.digit           <= '0;
        end else begin
            bus.InsideRectangle <= 1'b1;
            bus.offsetX         <= dx & 11'(DIGIT_W - 1);
            bus.offsetY         <= dy;
            bus.digit           <= {4'b0, nib};
        end
    end
endmodule

// File: tb/tb_score_digits_ctrl.sv
// Directed plus randomized checks of score_digits_ctrl against an arithmetic reference model.
module tb_score_digits_ctrl;
    localparam int TLX = 20;
    localparam int TLY = 20;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_val = 0;
    logic model_ovf = 1'b0;

    always #5 clk = ~clk;

    score_digits_ctrl_if #(.VALUE_W(14)) bus();

    score_digits_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected renderer inputs for a displayed decimal number.
    function automatic void model_pix(input int v, input int px, input int py,
                                      output int ins, output int ox, output int oy, output int dg);
        int slot, pw;
        ins = 0; ox = 0; oy = 0; dg = 0;
        if (px >= TLX && px < TLX + 64 && py >= TLY && py < TLY + 32) begin
            slot = (px - TLX) / 16;
            pw = 1;
            for (int j = 0; j < 3 - slot; j++) pw = pw * 10;
            if (!(slot < 3 && v < pw)) begin
                ins = 1;
                ox  = (px - TLX) % 16;
                oy  = py - TLY;
                dg  = (v / pw) % 10;
            end
        end
    endfunction

    task automatic check_pixel(input string tag, input int px, input int py);
        int ins, ox, oy, dg;
        @(negedge clk);
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
        @(posedge clk); #1;
        model_pix(model_val, px, py, ins, ox, oy, dg);
        chk({tag, "_ins"}, {31'b0, bus.InsideRectangle}, ins);
        chk({tag, "_offx"}, {21'b0, bus.offsetX}, ox);
        chk({tag, "_offy"}, {21'b0, bus.offsetY}, oy);
        chk({tag, "_digit"}, {24'b0, bus.digit}, dg);
    endtask

    task automatic sweep(input string tag);
        for (int s = 0; s < 4; s++) check_pixel({tag, "_slot"}, TLX + 16 * s + 7, TLY + 10);
        for (int r = 0; r < 4; r++)
            check_pixel({tag, "_rnd"}, int'($urandom_range(0, 100)), int'($urandom_range(0, 60)));
        chk({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, model_ovf});
    endtask

    // Leaves the caller at #1 after the edge that sampled startOfFrame.
    task automatic pulse(input int v);
        @(negedge clk);
        bus.value = 14'(v);
        bus.startOfFrame = 1'b1;
        @(posedge clk); #1;
        bus.startOfFrame = 1'b0;
    endtask

    task automatic convert(input int v);
        int n = 0;
        pulse(v);
        while (bus.busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("conv_timeout", {31'b0, bus.busy}, 0);
        model_ovf = (v > 9999);
        model_val = model_ovf ? 9999 : v;
    endtask

    initial begin
        int busy_cnt, v;
        bus.startOfFrame = 1'b0;
        bus.value = '0;
        bus.pixelX = '0;
        bus.pixelY = '0;

        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_ovf", {31'b0, bus.overflow}, 0);
        chk("rst_ins", {31'b0, bus.InsideRectangle}, 0);
        @(negedge clk) resetN = 1'b1;
        sweep("rst");

        // Latency: busy spans 15 samples, new digit appears after edge E+16.
        check_pixel("pre", TLX + 16, TLY + 5);
        pulse(1234);
        busy_cnt = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.busy === 1'b1) busy_cnt++;
            if (k == 15) chk("lat_old_digit", {24'b0, bus.digit}, 0);
            if (k == 16) begin
                chk("lat_digit", {24'b0, bus.digit}, 2);
                chk("lat_offx", {21'b0, bus.offsetX}, 0);
                chk("lat_offy", {21'b0, bus.offsetY}, 5);
                chk("lat_ins", {31'b0, bus.InsideRectangle}, 1);
            end
        end
        chk("busy_cycles", busy_cnt, 15);
        model_val = 1234;
        sweep("v1234");

        convert(7);    sweep("v7");
        convert(1005); sweep("v1005");
        convert(12000); sweep("sat");
        convert(42);   sweep("v42");

        // Second request mid-conversion must be dropped.
        pulse(1234);
        busy_cnt = 1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 6) begin
                @(negedge clk);
                bus.value = 14'd5678;
                bus.startOfFrame = 1'b1;
                @(posedge clk); #1;
                bus.startOfFrame = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (k == 14) chk("ign_busy_hi", {31'b0, bus.busy}, 1);
            if (k == 15) chk("ign_busy_fall", {31'b0, bus.busy}, 0);
        end
        chk("ign_busy_cycles", busy_cnt, 15);
        model_val = 1234;
        model_ovf = 1'b0;
        sweep("ign");

        check_pixel("bnd_left", TLX - 1, TLY);
        check_pixel("bnd_right", TLX + 64, TLY);
        check_pixel("bnd_corner", TLX + 63, TLY + 31);
        check_pixel("bnd_below", TLX + 20, TLY + 32);
        check_pixel("bnd_origin", TLX, TLY);

        for (int r = 0; r < 6; r++) begin
            v = int'($urandom_range(0, 16383));
            convert(v);
            sweep("rand");
        end

        // Reset during CONVERT with a saturated value pending.
        convert(15000);
        sweep("sat2");
        pulse(1234);
        repeat (4) @(posedge clk);
        @(negedge clk) resetN = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_busy", {31'b0, bus.busy}, 0);
        chk("rstmid_ovf", {31'b0, bus.overflow}, 0);
        @(negedge clk) resetN = 1'b1;
        model_val = 0;
        model_ovf = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rstmid_idle", {31'b0, bus.busy}, 0);
        sweep("rstmid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
